// File: rtl/nco_freq_meter_if.sv
// Sample stream in, frequency measurement out, between the NCO side and the meter.
interface nco_freq_meter_if #(
   parameter int mpr = 11,
   parameter int apr = 32
);
   logic                  clken;
   logic signed [mpr-1:0] fsin_i;
   logic                  in_valid;
   logic [apr-1:0]        phi_inc_o;
   logic                  meas_valid_o;
   logic                  ovf_o;
   logic                  lost_o;
   logic                  locked_o;

   modport master (
      output clken, fsin_i, in_valid,
      input  phi_inc_o, meas_valid_o, ovf_o, lost_o, locked_o
   );

   modport slave (
      input  clken, fsin_i, in_valid,
      output phi_inc_o, meas_valid_o, ovf_o, lost_o, locked_o
   );
endinterface

// File: rtl/nco_freq_meter.sv
// Measures the NCO sample period over 2^log2np rising zero crossings and
// converts the sample count into an equivalent apr-bit phase increment.
//
// state | meaning
// IDLE  | waiting for the first rising crossing
// COUNT | window in progress, counting accepted samples and crossings
module nco_freq_meter #(
   parameter int mpr    = 11,
   parameter int apr    = 32,
   parameter int cw     = 24,
   parameter int log2np = 3,
   parameter int hyst   = 16
) (
   input  logic clk,
   input  logic reset_n,
   nco_freq_meter_if.slave bus
);
   localparam int np  = 1 << log2np;
   localparam int pw  = (log2np > 0) ? log2np : 1;
   localparam int dcw = $clog2(apr + 1);
   localparam logic signed [mpr-1:0] hyst_p = mpr'(hyst);
   localparam logic signed [mpr-1:0] hyst_n = -hyst_p;

   typedef enum logic {IDLE, COUNT} state_t;

   state_t         state, state_n;
   logic [cw-1:0]  cnt, cnt_n;
   logic [pw-1:0]  per, per_n;
   logic           neg, neg_n;
   logic           acc, is_low, is_high, xing;
   logic           win_end, ovf_evt, ovf_pend;

   logic           div_busy;
   logic [dcw-1:0] div_cnt;
   logic [cw:0]    rem, dvs;
   logic [apr-1:0] quo, quo_nx;
   logic [cw+1:0]  rem2, diff;
   logic           ge, last_iter, div_free, div_start;

   assign acc     = bus.clken & bus.in_valid;
   assign is_low  = bus.fsin_i <= hyst_n;
   assign is_high = bus.fsin_i >= hyst_p;
   assign xing    = acc & neg & is_high;

   always_comb begin
      neg_n = neg;
      if (acc) begin
         if (is_low)
            neg_n = 1'b1;
         else if (xing)
            neg_n = 1'b0;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      per_n   = per;
      win_end = 1'b0;
      ovf_evt = 1'b0;
      if (acc) begin
         case (state)
            IDLE: begin
               if (xing) begin
                  state_n = COUNT;
                  cnt_n   = '0;
                  per_n   = '0;
               end
            end
            COUNT: begin
               // Window end restarts the count from the ending crossing, so
               // windows are back to back and never hit the overflow check.
               if (xing && per == pw'(np - 1)) begin
                  win_end = 1'b1;
                  cnt_n   = '0;
                  per_n   = '0;
               end else if (cnt == {cw{1'b1}}) begin
                  ovf_evt = 1'b1;
                  state_n = IDLE;
               end else begin
                  cnt_n = cnt + 1'b1;
                  if (xing)
                     per_n = per + 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         per   <= '0;
         neg   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         per   <= per_n;
         neg   <= neg_n;
      end
   end

   // rem < dvs always, so rem2 < 2^(cw+1) and diff's top bit is a valid borrow.
   assign rem2      = {rem, 1'b0};
   assign diff      = rem2 - {1'b0, dvs};
   assign ge        = ~diff[cw+1];
   assign quo_nx    = {quo[apr-2:0], ge};
   assign last_iter = div_busy && (div_cnt == '0);
   assign div_free  = !div_busy || last_iter;
   assign div_start = win_end && div_free;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_busy <= 1'b0;
         div_cnt  <= '0;
         rem      <= '0;
         dvs      <= '0;
         quo      <= '0;
      end else if (div_start) begin
         div_busy <= 1'b1;
         div_cnt  <= dcw'(apr - 1);
         rem      <= (cw + 1)'(np);
         dvs      <= {1'b0, cnt} + (cw + 1)'(1);
         quo      <= '0;
      end else if (div_busy) begin
         rem <= ge ? diff[cw:0] : rem2[cw:0];
         quo <= quo_nx;
         if (div_cnt == '0)
            div_busy <= 1'b0;
         else
            div_cnt <= div_cnt - 1'b1;
      end
   end

   // A divider result wins the output slot; a coincident overflow waits a cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.phi_inc_o    <= '0;
         bus.meas_valid_o <= 1'b0;
         bus.ovf_o        <= 1'b0;
         bus.lost_o       <= 1'b0;
         ovf_pend         <= 1'b0;
      end else begin
         bus.lost_o <= win_end && !div_free;
         if (last_iter) begin
            bus.phi_inc_o    <= quo_nx;
            bus.meas_valid_o <= 1'b1;
            bus.ovf_o        <= 1'b0;
            ovf_pend         <= ovf_evt;
         end else if (ovf_evt || ovf_pend) begin
            bus.phi_inc_o    <= '0;
            bus.meas_valid_o <= 1'b1;
            bus.ovf_o        <= 1'b1;
            ovf_pend         <= 1'b0;
         end else begin
            bus.meas_valid_o <= 1'b0;
            bus.ovf_o        <= 1'b0;
         end
      end
   end

   assign bus.locked_o = (state == COUNT);
endmodule

// File: tb/tb_nco_freq_meter.sv
// Bench for nco_freq_meter: NCO sine, square, alternating, DC and random
// stimulus compared every cycle against a timestamp-based window model.
module tb_nco_freq_meter;
   localparam int  MPR = 11, APR = 32, CW = 10, L2NP = 3, HYST = 16;
   localparam int  NP = 1 << L2NP;
   localparam int  NCYC = 16384;
   localparam real PI = 3.14159265358979;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   nco_freq_meter_if #(.mpr(MPR), .apr(APR)) bus ();
   nco_freq_meter #(.mpr(MPR), .apr(APR), .cw(CW), .log2np(L2NP), .hyst(HYST))
      dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   bit          ev_mv[NCYC];
   bit          ev_ovf[NCYC];
   bit          ev_lost[NCYC];
   logic [31:0] ev_phi[NCYC];

   bit          m_neg = 0, m_locked = 0, chk_locked = 0;
   int          m_n = 0, m_k = 0, m_last_start = -1000000;
   logic [31:0] exp_phi = '0;
   logic [31:0] nco_ph = '0;
   int          errs = 0, checks = 0;
   int          dut_ovf = 0, dut_lost = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (cyc < NCYC) begin
         if (ev_mv[cyc]) exp_phi = ev_phi[cyc];
         chk("meas_valid", bus.meas_valid_o, ev_mv[cyc]);
         chk("ovf", bus.ovf_o, ev_ovf[cyc]);
         chk("lost", bus.lost_o, ev_lost[cyc]);
         chk("locked", bus.locked_o, chk_locked);
         chk("phi_inc", bus.phi_inc_o, exp_phi);
         if (bus.lost_o) dut_lost++;
         if (bus.meas_valid_o && bus.ovf_o) dut_ovf++;
      end
   end

   task automatic sched(input int t, input bit ovf, input logic [31:0] phi);
      if (t < NCYC) begin
         ev_mv[t]  = 1'b1;
         ev_ovf[t] = ovf;
         ev_phi[t] = phi;
      end
   endtask

   // Window model: sample counts and result timestamps from the measurement rules.
   task automatic model_step(input int t, input int s);
      bit lo, hi, x;
      int d, tt;
      logic [63:0] q;
      lo = (s <= -HYST);
      hi = (s >= HYST);
      x  = m_neg && hi;
      if (lo) m_neg = 1'b1;
      else if (x) m_neg = 1'b0;
      if (!m_locked) begin
         if (x) begin
            m_locked = 1'b1;
            m_n = 0;
            m_k = 0;
         end
      end else if (x && m_k == NP - 1) begin
         d = m_n + 1;
         m_n = 0;
         m_k = 0;
         if (t >= m_last_start + APR) begin
            m_last_start = t;
            q = (64'd1 << (APR + L2NP)) / 64'(d);
            sched(t + APR + 1, 1'b0, q[31:0]);
         end else if (t + 1 < NCYC) begin
            ev_lost[t + 1] = 1'b1;
         end
      end else if (m_n == (1 << CW) - 1) begin
         m_locked = 1'b0;
         tt = (t + 1 < NCYC && ev_mv[t + 1]) ? t + 2 : t + 1;
         sched(tt, 1'b1, 32'h0);
      end else begin
         m_n++;
         if (x) m_k++;
      end
   endtask

   task automatic drive(input int s, input bit ce, input bit v);
      @(posedge clk);
      #1;
      bus.clken    = ce;
      bus.in_valid = v;
      bus.fsin_i   = s[MPR-1:0];
      chk_locked   = m_locked;
      if (ce && v && reset_n) model_step(cyc, s);
   endtask

   task automatic run_nco(input int n, input logic [31:0] inc, input int amp,
                          input int mode, input int noise);
      int s;
      bit ce, v;
      for (int i = 0; i < n; i++) begin
         ce = 1'b1;
         v  = 1'b1;
         if (mode == 1) begin
            ce = (i % 2 == 0);
            v  = (i % 4 != 3);
         end else if (mode == 2) begin
            ce = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 4) != 0);
         end
         s = $rtoi(real'(amp) * $sin(2.0 * PI * real'(nco_ph) / 4294967296.0));
         if (noise > 0) s = s + int'($urandom_range(0, 2 * noise)) - noise;
         if (s > 1023) s = 1023;
         if (s < -1023) s = -1023;
         drive(s, ce, v);
         if (ce && v) nco_ph = nco_ph + inc;
      end
   endtask

   task automatic run_square(input int n);
      int p;
      for (int i = 0; i < n; i++) begin
         p = i % 20;
         if (p < 8) drive(1000, 1'b1, 1'b1);
         else if (p >= 10 && p < 18) drive(-1000, 1'b1, 1'b1);
         else drive(int'($urandom_range(0, 20)) - 10, 1'b1, 1'b1);
      end
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      bus.in_valid = 1'b0;
      for (int c = 0; c < NCYC; c++) begin
         if (c >= cyc) begin
            ev_mv[c] = 1'b0;
            ev_ovf[c] = 1'b0;
            ev_lost[c] = 1'b0;
         end
      end
      m_neg = 0;
      m_locked = 0;
      m_n = 0;
      m_k = 0;
      m_last_start = -1000000;
      chk_locked = 0;
      exp_phi = '0;
      #1;
      chk("rst_phi", bus.phi_inc_o, 32'h0);
      chk("rst_mv", bus.meas_valid_o, 1'b0);
      chk("rst_locked", bus.locked_o, 1'b0);
      chk("rst_lost", bus.lost_o, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int prev, found;
      bus.clken = 1'b0;
      bus.in_valid = 1'b0;
      bus.fsin_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("init_phi", bus.phi_inc_o, 32'h0);
      chk("init_mv", bus.meas_valid_o, 1'b0);
      chk("init_ovf", bus.ovf_o, 1'b0);
      chk("init_locked", bus.locked_o, 1'b0);
      reset_n = 1'b1;

      run_nco(700, 32'h1000_0000, 1000, 0, 0);
      chk("sine16_phi", bus.phi_inc_o, 32'h1000_0000);

      run_nco(1200, 32'h1000_0000, 1000, 1, 0);
      chk("sine16_gapped_phi", bus.phi_inc_o, 32'h1000_0000);

      run_square(1200);
      chk("square20_phi", bus.phi_inc_o, 32'h0CCC_CCCC);

      prev = dut_ovf;
      drive(-500, 1'b1, 1'b1);
      drive(500, 1'b1, 1'b1);
      for (int i = 0; i < 1100; i++) drive(500, 1'b1, 1'b1);
      chk("dc_ovf_count", dut_ovf - prev, 1);
      chk("dc_phi", bus.phi_inc_o, 32'h0);
      chk("dc_locked", bus.locked_o, 1'b0);

      run_nco(500, 32'h1000_0000, 1000, 0, 0);
      chk("relock_phi", bus.phi_inc_o, 32'h1000_0000);

      prev = dut_lost;
      for (int i = 0; i < 300; i++) drive((i % 2) ? -1000 : 1000, 1'b1, 1'b1);
      chk("alt_phi", bus.phi_inc_o, 32'h8000_0000);
      chk("alt_lost_seen", (dut_lost - prev) > 0, 1);

      for (int seg = 0; seg < 6; seg++)
         run_nco(500, $urandom_range(32'd35791394, 32'd715827882),
                 $urandom_range(200, 1023), 2, $urandom_range(0, 8));

      found = 0;
      for (int i = 0; i < 600 && found == 0; i++) begin
         run_nco(1, 32'h1000_0000, 1000, 0, 0);
         if (m_last_start >= 0 && cyc - m_last_start == 10) found = 1;
      end
      chk("div_in_flight_found", found, 1);
      apply_reset();
      for (int i = 0; i < 60; i++) drive(0, 1'b1, 1'b1);
      run_nco(400, 32'h1000_0000, 1000, 0, 0);
      chk("post_reset_phi", bus.phi_inc_o, 32'h1000_0000);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
